// File: rtl/instr_encoder_pkg.sv
// -----------------------------------------------------------------------------
// instr_encoder_pkg
// Shared definitions for the RiSC-16 instruction encoder:
//   - word / field widths (WORD_LEN, REG_ADDR_LEN, OPCODE_LEN)
//   - opcode constants ADD, ADDI, NAND, LUI, SW, LW, BEQ, JALR
//   - FSM state encodings (enc_state_e)
//   - encode_word(): packs instruction fields into a 16-bit word
//   - imm_legal():   immediate range test used when ENC_RANGE_CHECK_EN is set
// -----------------------------------------------------------------------------
package instr_encoder_pkg;

    localparam int WORD_LEN     = 16;
    localparam int REG_ADDR_LEN = 3;
    localparam int OPCODE_LEN   = 3;

    localparam logic [OPCODE_LEN-1:0] ADD  = 3'b000;
    localparam logic [OPCODE_LEN-1:0] ADDI = 3'b001;
    localparam logic [OPCODE_LEN-1:0] NAND = 3'b010;
    localparam logic [OPCODE_LEN-1:0] LUI  = 3'b011;
    localparam logic [OPCODE_LEN-1:0] SW   = 3'b100;
    localparam logic [OPCODE_LEN-1:0] LW   = 3'b101;
    localparam logic [OPCODE_LEN-1:0] BEQ  = 3'b110;
    localparam logic [OPCODE_LEN-1:0] JALR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_FLUSH = 2'b10,
        ST_DONE  = 2'b11
    } enc_state_e;

    // Pack one instruction. The opcode and rega fields sit in the same place
    // for every format; the low 10 bits depend on the format.
    function automatic logic [WORD_LEN-1:0] encode_word(
        input logic [OPCODE_LEN-1:0]   op,
        input logic [REG_ADDR_LEN-1:0] ra,
        input logic [REG_ADDR_LEN-1:0] rb,
        input logic [REG_ADDR_LEN-1:0] rc,
        input logic [WORD_LEN-1:0]     imm
    );
        logic [WORD_LEN-1:0] w;
        w        = '0;
        w[15:13] = op;
        w[12:10] = ra;
        case (op)
            ADD, NAND: begin
                // RRR: bits [6:3] stay zero
                w[9:7] = rb;
                w[2:0] = rc;
            end
            LUI: begin
                // RI: upper 10 bits of the target value
                w[9:0] = imm[15:6];
            end
            JALR: begin
                // RRI with a forced zero immediate
                w[9:7] = rb;
            end
            default: begin
                // ADDI, SW, LW, BEQ: 7-bit signed immediate
                w[9:7] = rb;
                w[6:0] = imm[6:0];
            end
        endcase
        return w;
    endfunction

    // An RRI immediate fits in 7 signed bits only when bits [15:6] are all
    // copies of the sign. LUI can only represent multiples of 64.
    function automatic logic imm_legal(
        input logic [OPCODE_LEN-1:0] op,
        input logic [WORD_LEN-1:0]   imm
    );
        logic ok;
        ok = 1'b1;
        case (op)
            ADDI, SW, LW, BEQ: ok = (imm[15:6] == 10'h000) || (imm[15:6] == 10'h3FF);
            LUI:               ok = (imm[5:0] == 6'd0);
            default:           ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// -----------------------------------------------------------------------------
// enc_fifo
// Synchronous single-clock FIFO for encoded words, DEPTH x WIDTH.
// The head entry is presented combinationally on rdata so a word pushed on
// one edge is visible at the output right after that edge.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   write strobe and data (caller must not push when full)
//   pop           remove head entry (caller must not pop when empty)
//   rdata         head entry
//   full, empty   occupancy flags
// -----------------------------------------------------------------------------
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wen;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // One write enable per storage entry.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wen
            localparam logic [AW-1:0] IDX = gi;
            assign wen[gi] = push && (wr_ptr_q[AW-1:0] == IDX);
        end
    endgenerate

    // Storage needs no reset: contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wen[i]) begin
                mem_q[i] <= wdata;
            end
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Accepts RiSC-16 instruction fields during a load session, encodes them into
// 16-bit words, buffers them in enc_fifo and writes them to instruction memory
// at consecutive addresses starting at base_addr (address wraps at 0xFFFF).
//
// Session: start (IDLE->LOAD), finish (LOAD->FLUSH), FIFO drained
// (FLUSH->DONE), one cycle later back to IDLE with a done pulse in DONE.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   start, base_addr             begin session, first write address
//   finish                       stop accepting fields
//   in_valid/in_ready            field handshake
//   opcode, rega, regb, regc, imm  instruction fields
//   mem_we/mem_ready             memory write handshake
//   mem_addr, mem_wdata          write address / encoded word
//   busy, done, err              status (err: illegal immediate dropped)
//
// Build option: define ENC_RANGE_CHECK_EN to drop transfers whose immediate
// cannot be represented and raise err; otherwise immediates are truncated
// and err is tied low.
// -----------------------------------------------------------------------------
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WORD_LEN-1:0]     base_addr,
    input  logic                    finish,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_LEN-1:0]   opcode,
    input  logic [REG_ADDR_LEN-1:0] rega,
    input  logic [REG_ADDR_LEN-1:0] regb,
    input  logic [REG_ADDR_LEN-1:0] regc,
    input  logic [WORD_LEN-1:0]     imm,
    output logic                    mem_we,
    input  logic                    mem_ready,
    output logic [WORD_LEN-1:0]     mem_addr,
    output logic [WORD_LEN-1:0]     mem_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    enc_state_e          state_q;
    logic                busy_q;
    logic                done_q;
    logic [WORD_LEN-1:0] addr_q, addr_d;

    logic                xfer;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WORD_LEN-1:0] fifo_rdata;
    logic [WORD_LEN-1:0] enc_word;
    logic                start_ok;

    assign start_ok = (state_q == ST_IDLE) && start;
    assign enc_word = encode_word(opcode, rega, regb, regc, imm);

    // in_ready deliberately ignores a pop in the same cycle: a full FIFO
    // refuses input even when the memory is draining it.
    assign in_ready = (state_q == ST_LOAD) && !fifo_full;
    assign xfer     = in_valid && in_ready;

    assign mem_we    = !fifo_empty && ((state_q == ST_LOAD) || (state_q == ST_FLUSH));
    assign pop       = mem_we && mem_ready;
    assign mem_addr  = addr_q;
    assign mem_wdata = fifo_rdata;

`ifdef ENC_RANGE_CHECK_EN
    logic imm_ok;
    logic err_q, err_d;

    assign imm_ok = imm_legal(opcode, imm);
    // An illegal transfer still completes the handshake but never reaches
    // the FIFO, so the address counter does not advance for it.
    assign push   = xfer && imm_ok;

    always_comb begin
        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end else if (xfer && !imm_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign push = xfer;
    assign err  = 1'b0;
`endif

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_LEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Address counter: reloaded on an accepted start, stepped on each
    // completed memory write; 16-bit arithmetic wraps 0xFFFF -> 0x0000.
    always_comb begin
        addr_d = addr_q;
        if (start_ok) begin
            addr_d = base_addr;
        end else if (pop) begin
            addr_d = addr_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Session FSM with registered busy/done. A transfer in the same cycle as
    // finish is still accepted because in_ready depends only on LOAD state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (finish) begin
                        state_q <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (fifo_empty) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
// Directed sessions against instr_encoder with a scoreboard of expected memory
// writes computed from the instruction-format rules, plus literal checks on
// the written log. Inputs change 1 time unit after the rising edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0000;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  opcode = 3'd0;
    logic [2:0]  rega = 3'd0;
    logic [2:0]  regb = 3'd0;
    logic [2:0]  regc = 3'd0;
    logic [15:0] imm = 16'h0000;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .finish    (finish),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rega      (rega),
        .regb      (regb),
        .regc      (regc),
        .imm       (imm),
        .mem_we    (mem_we),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Scoreboard of writes still expected, and log of writes seen.
    logic [15:0] exp_addr_q [$];
    logic [15:0] exp_data_q [$];
    logic [15:0] wlog_addr  [$];
    logic [15:0] wlog_data  [$];
    logic [15:0] model_addr = 16'h0000;
    int          acc_cnt = 0;
    bit          prev_stall = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word value from the format rules, using plain field weights.
    function automatic logic [15:0] model_word(input int op, input int ra, input int rb,
                                               input int rc, input int im);
        int w;
        w = op * 8192 + ra * 1024;
        if (op == 0 || op == 2)      w = w + rb * 128 + rc;
        else if (op == 3)            w = w + im / 64;
        else if (op == 7)            w = w + rb * 128;
        else                         w = w + rb * 128 + (im % 128);
        return w[15:0];
    endfunction

    function automatic bit model_legal(input int op, input int im);
`ifdef ENC_RANGE_CHECK_EN
        int s;
        s = (im >= 32768) ? im - 65536 : im;
        if (op == 1 || op == 4 || op == 5 || op == 6) return (s >= -64) && (s <= 63);
        if (op == 3) return (im % 64) == 0;
`endif
        return 1'b1;
    endfunction

    // Per-cycle compare: whenever mem_we is high the outputs must show the
    // oldest expected write; it leaves the scoreboard when mem_ready accepts.
    task automatic monitor_step();
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (in_valid && in_ready) acc_cnt++;
            if (prev_stall) chk("stall_hold_we", mem_we, 1'b1);
            if (mem_we) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    chk("wr_addr", mem_addr, exp_addr_q[0]);
                    chk("wr_data", mem_wdata, exp_data_q[0]);
                    if (mem_ready) begin
                        $display("write addr=0x%04h data=0x%04h", mem_addr, mem_wdata);
                        void'(exp_addr_q.pop_front());
                        void'(exp_data_q.pop_front());
                    end
                end
                if (mem_ready) begin
                    wlog_addr.push_back(mem_addr);
                    wlog_data.push_back(mem_wdata);
                end
            end
            prev_stall = mem_we && !mem_ready;
        end
    endtask

    task automatic do_start(input logic [15:0] b);
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = b;
        model_addr = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic pulse_finish();
        @(posedge clk); #1;
        finish = 1'b1;
        @(posedge clk); #1;
        finish = 1'b0;
    endtask

    task automatic send(input int op, input int ra, input int rb, input int rc,
                        input int im, input bit fin);
        bit ok;
        @(posedge clk); #1;
        opcode = op[2:0];
        rega = ra[2:0];
        regb = rb[2:0];
        regc = rc[2:0];
        imm = im[15:0];
        in_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_accept: in_ready stayed 0 for 100 cycles, expected 1");
            in_valid = 1'b0;
        end else begin
            finish = fin;
            @(posedge clk); #1;
            in_valid = 1'b0;
            finish = 1'b0;
            $display("accept op=%0d ra=%0d rb=%0d rc=%0d imm=0x%04h fin=%0d", op, ra, rb, rc, im, fin);
            if (model_legal(op, im)) begin
                exp_addr_q.push_back(model_addr);
                exp_data_q.push_back(model_word(op, ra, rb, rc, im));
                model_addr = model_addr + 16'd1;
            end
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1'b1);
        if (seen) begin
            chk("busy_in_done", busy, 1'b1);
            chk("pending_at_done", exp_addr_q.size(), 0);
            @(negedge clk);
            chk("done_one_cycle", done, 1'b0);
            chk("busy_after_done", busy, 1'b0);
        end
    endtask

    initial begin
        int n0;
        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);

        // Single add at 0x0010
        n0 = wlog_addr.size();
        do_start(16'h0010);
        send(0, 1, 2, 3, 0, 1'b0);
        pulse_finish();
        wait_done();
        chk("t1_count", wlog_addr.size() - n0, 1);
        chk("t1_addr", wlog_addr[n0], 16'h0010);
        chk("t1_data", wlog_data[n0], 16'h0503);

        // addi / lui / jalr formats, last transfer alongside finish
        n0 = wlog_addr.size();
        do_start(16'h0100);
        send(1, 1, 0, 0, 'hFFFF, 1'b0);
        send(3, 7, 0, 0, 'hFFC0, 1'b0);
        send(7, 7, 6, 0, 'h1234, 1'b1);
        wait_done();
        chk("t2_count", wlog_addr.size() - n0, 3);
        chk("t2_addi", wlog_data[n0], 16'h247F);
        chk("t2_lui", wlog_data[n0+1], 16'h7FFF);
        chk("t2_jalr", wlog_data[n0+2], 16'hFF00);
        chk("t2_addr_last", wlog_addr[n0+2], 16'h0102);

        // Memory stalled for 10 cycles while 6 words are offered
        n0 = wlog_addr.size();
        do_start(16'h0200);
        mem_ready = 1'b0;
        fork
            begin
                send(2, 3, 4, 5, 0, 1'b0);
                send(4, 2, 3, 0, 'hFFC0, 1'b0);
                send(5, 1, 1, 0, 63, 1'b0);
                send(6, 0, 7, 0, 'hFFF0, 1'b0);
                send(0, 7, 7, 7, 0, 1'b0);
                send(1, 3, 3, 0, 5, 1'b0);
            end
            begin
                int a0;
                a0 = acc_cnt;
                repeat (10) @(negedge clk);
                chk("t3_in_ready_full", in_ready, 1'b0);
                chk("t3_accepts_before_full", acc_cnt - a0, 4);
                chk("t3_mem_we_stalled", mem_we, 1'b1);
                chk("t3_stalled_addr", mem_addr, 16'h0200);
                @(posedge clk); #1;
                mem_ready = 1'b1;
            end
        join
        pulse_finish();
        wait_done();
        chk("t3_count", wlog_addr.size() - n0, 6);
        chk("t3_nand", wlog_data[n0], 16'h4E05);
        chk("t3_sw", wlog_data[n0+1], 16'h89C0);
        chk("t3_addr_last", wlog_addr[n0+5], 16'h0205);

        // Address wrap
        n0 = wlog_addr.size();
        do_start(16'hFFFE);
        send(0, 1, 1, 1, 0, 1'b0);
        send(2, 2, 2, 2, 0, 1'b0);
        send(1, 4, 4, 0, 1, 1'b1);
        wait_done();
        chk("t4_addr0", wlog_addr[n0], 16'hFFFE);
        chk("t4_addr1", wlog_addr[n0+1], 16'hFFFF);
        chk("t4_addr2", wlog_addr[n0+2], 16'h0000);
        chk("t4_addr_after", mem_addr, 16'h0001);

        // Out-of-range addi immediate followed by a valid add
        n0 = wlog_addr.size();
        do_start(16'h0300);
        send(1, 1, 0, 0, 64, 1'b0);
        send(0, 1, 2, 3, 0, 1'b1);
        wait_done();
`ifdef ENC_RANGE_CHECK_EN
        chk("t5_err", err, 1'b1);
        chk("t5_count", wlog_addr.size() - n0, 1);
        chk("t5_addr", wlog_addr[n0], 16'h0300);
        chk("t5_data", wlog_data[n0], 16'h0503);
`else
        chk("t5_err", err, 1'b0);
        chk("t5_count", wlog_addr.size() - n0, 2);
        chk("t5_trunc", wlog_data[n0], 16'h2440);
        chk("t5_addr", wlog_addr[n0+1], 16'h0301);
`endif

        // Reset in FLUSH with two words buffered
        do_start(16'h0400);
        @(negedge clk);
        chk("t6_err_cleared", err, 1'b0);
        mem_ready = 1'b0;
        send(0, 1, 2, 3, 0, 1'b0);
        send(2, 4, 5, 6, 0, 1'b0);
        pulse_finish();
        @(negedge clk);
        chk("t6_busy_flush", busy, 1'b1);
        chk("t6_we_flush", mem_we, 1'b1);
        chk("t6_in_ready_flush", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t6_we_after_rst", mem_we, 1'b0);
        chk("t6_busy_after_rst", busy, 1'b0);
        chk("t6_in_ready_after_rst", in_ready, 1'b0);
        chk("t6_addr_after_rst", mem_addr, 16'h0000);
        mem_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("t6_no_write", mem_we, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of encoded-word buffer entries (power of 2, >=2).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load session.
- base_addr  in  16  first memory address of the session; sampled on start.
- finish  in  1  one-cycle pulse that ends input acceptance.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  encoder can accept fields.
- opcode  in  3  RiSC-16 opcode.
- rega / regb / regc  in  3 each  register fields.
- imm  in  16  immediate: signed value for RRI; full target word for lui.
- mem_we  out  1  write request to instruction memory.
- mem_ready  in  1  memory accepts the write this cycle.
- mem_addr  out  16  write address.
- mem_wdata  out  16  encoded instruction.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the session completes.
- err  out  1  sticky flag: an illegal immediate was dropped.

Function
REQ-003 SHALL encode opcode into [15:13], rega into [12:10] and regb into [9:7] for every opcode.
REQ-004 SHALL encode add (000) and nand (010) as RRR: [6:3]=0, [2:0]=regc.
REQ-005 SHALL encode addi (001), sw (100), lw (101) and beq (110) as RRI: [6:0]=imm[6:0].
REQ-006 SHALL encode lui (011) as RI: [9:0]=imm[15:6]; regb is ignored.
REQ-007 SHALL encode jalr (111) as RRI with [6:0]=0, regardless of imm.
REQ-008 SHALL implement the FSM IDLE -> LOAD on start; LOAD -> FLUSH on finish; FLUSH -> DONE when the FIFO is empty; DONE -> IDLE unconditionally after one cycle.
REQ-009 SHALL ignore start outside IDLE and finish outside LOAD.
REQ-010 SHALL load the write address from base_addr on start and clear err on start.
REQ-011 SHALL drive in_ready = (state==LOAD) && FIFO not full, with no bypass of simultaneous push and pop when the FIFO is full.
REQ-012 SHALL transfer fields when in_valid && in_ready; the encoded word is pushed into the FIFO.
REQ-013 SHALL accept a transfer in the same cycle as finish, then move to FLUSH.
REQ-014 SHALL drive mem_we = FIFO not empty && state in {LOAD, FLUSH}, with mem_wdata = FIFO head and mem_addr = the address counter.
REQ-015 SHALL pop the FIFO and increment the address when mem_we && mem_ready.
REQ-016 SHALL wrap the address from 0xFFFF to 0x0000.
REQ-017 SHALL hold mem_addr and mem_wdata stable while mem_we=1 and mem_ready=0.
REQ-018 SHALL have a minimum latency of 1 cycle from accepting fields to the first cycle with mem_we=1 for that word.
REQ-019 SHALL support one push and one pop per cycle; in that cycle the occupancy is unchanged.
REQ-020 SHALL drive done=1 for exactly the cycle the FSM is in DONE.
REQ-021 SHALL drive busy=1 in LOAD, FLUSH and DONE.

Reset
REQ-022 SHALL, on rst, set the state to IDLE, empty the FIFO, set the address to 0x0000, and set err=0, done=0, busy=0, in_ready=0 and mem_we=0.
REQ-023 SHALL abort a session when rst is asserted mid-session: FIFO contents are discarded and no further mem_we occurs.

Configuration
REQ-024 SHALL, when ENC_RANGE_CHECK_EN is defined, check immediates on each transfer:
- An RRI imm outside -64..63 is illegal.
- A lui imm with imm[5:0]!=0 is illegal.
- An illegal transfer is consumed (handshake completes), is not pushed, and sets err=1.
REQ-025 SHALL, when ENC_RANGE_CHECK_EN is not defined, silently truncate immediates per REQ-005/REQ-006; err is tied to 0.

Structure
REQ-026 SHALL take the following from the shared defines file:
- opcode constants: ADD, ADDI, NAND, LUI, SW, LW, BEQ, JALR;
- WORD_LEN, REG_ADDR_LEN;
- the FSM state encodings.
REQ-027 SHALL implement the buffer as one sub-module, enc_fifo: synchronous, FIFO_DEPTH x 16, with full/empty flags.

Verification
REQ-028 SHALL cover: start with base_addr=0x0010; add rega=1, regb=2, regc=3; finish -> single write mem_addr=0x0010, mem_wdata=0x0503, then done pulse.
REQ-029 SHALL cover: addi rega=1, regb=0, imm=0xFFFF (-1) -> mem_wdata=0x247F; lui rega=7, imm=0xFFC0 -> 0x7FFF; jalr rega=7, regb=6 -> 0xFF00.
REQ-030 SHALL cover: mem_ready=0 for 10 cycles while 6 words are offered with FIFO_DEPTH=4 -> in_ready falls after 4 accepts; mem_addr/mem_wdata stay stable; all 6 words are later written in order.
REQ-031 SHALL cover: base_addr=0xFFFE, 3 instructions -> addresses 0xFFFE, 0xFFFF, 0x0000.
REQ-032 SHALL cover, with ENC_RANGE_CHECK_EN: addi imm=64 -> err=1, no write; the next valid add is written at the unadvanced address.
REQ-033 SHALL cover: rst asserted in FLUSH with 2 words buffered -> next cycle mem_we=0, busy=0, state IDLE.
